// File: rtl/mem_port.sv
// Memory-stage load/store responder driving an asynchronous SRAM bus.
// Optional MEMPORT_WAIT_EN stretches RD and WR_PULSE by WAIT_CYCLES cycles.
module mem_port #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread_in,
    input  logic        memwrite_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    output logic [15:0] rdata_out,
    output logic        stall_out,
    output logic [17:0] ram_addr,
    inout  wire  [15:0] ram_data,
    output logic        ram_en_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StDone
    } state_e;

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_port: WAIT_CYCLES must be in 1..15");
    end

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        en_n_q, en_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        drive_q, drive_d;
    logic        last_cycle;

`ifdef MEMPORT_WAIT_EN
    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);
    logic [3:0] cnt_q, cnt_d;

    assign last_cycle = (cnt_q == 4'd0);
`else
    assign last_cycle = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MEMPORT_WAIT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                // A simultaneous read is dropped: the write takes priority.
                if (memwrite_in) begin
                    addr_d  = addr_in;
                    wdata_d = wdata_in;
                    state_d = StWrSetup;
                end else if (memread_in) begin
                    addr_d  = addr_in;
                    state_d = StRd;
`ifdef MEMPORT_WAIT_EN
                    cnt_d   = WaitLoad;
`endif
                end
            end
            StRd: begin
                if (last_cycle) begin
                    rdata_d = ram_data;
                    state_d = StDone;
                end else begin
`ifdef MEMPORT_WAIT_EN
                    cnt_d = cnt_q - 4'd1;
`endif
                end
            end
            StWrSetup: begin
                state_d = StWrPulse;
`ifdef MEMPORT_WAIT_EN
                cnt_d   = WaitLoad;
`endif
            end
            StWrPulse: begin
                if (last_cycle) begin
                    state_d = StWrHold;
                end else begin
`ifdef MEMPORT_WAIT_EN
                    cnt_d = cnt_q - 4'd1;
`endif
                end
            end
            StWrHold: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Strobes are registered from the next state so they line up with state_q.
    always_comb begin
        en_n_d  = !(state_d inside {StRd, StWrSetup, StWrPulse, StWrHold});
        oe_n_d  = (state_d != StRd);
        we_n_d  = (state_d != StWrPulse);
        drive_d = (state_d inside {StWrSetup, StWrPulse, StWrHold});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            en_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            drive_q <= 1'b0;
`ifdef MEMPORT_WAIT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            en_n_q  <= en_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            drive_q <= drive_d;
`ifdef MEMPORT_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign stall_out = ((state_q == StIdle) && (memread_in || memwrite_in)) ||
                       (state_q inside {StRd, StWrSetup, StWrPulse, StWrHold});

    assign rdata_out = rdata_q;
    assign ram_addr  = {2'b00, addr_q};
    assign ram_en_n  = en_n_q;
    assign ram_oe_n  = oe_n_q;
    assign ram_we_n  = we_n_q;
    assign ram_data  = drive_q ? wdata_q : 16'hzzzz;

endmodule

// File: doc/mem_port.md
# mem_port

Memory-stage responder that services the load/store requests issued by the EXE/MEM pipeline register (memread, memwrite, ALU-computed address, store data) and runs the corresponding transaction on the external asynchronous SRAM bus. It sequences the SRAM strobes with a small state machine and drives the bus tri-state. It stalls the pipeline until each access completes and returns load data for the MEM/WB stage.

## Interface
- WAIT_CYCLES, 2: extra strobe-hold cycles per access, used only when MEMPORT_WAIT_EN is defined (legal 1..15)
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- memread_in  input  1  load request, level, held until stall_out drops
- memwrite_in  input  1  store request, level, held until stall_out drops
- addr_in  input  16  word address (ALU result)
- wdata_in  input  16  store data
- rdata_out  output  16  last load data; reset 0
- stall_out  output  1  freeze upstream pipeline; reset 0
- ram_addr  output  18  SRAM address, {2'b00, latched addr}; reset 0
- ram_data  inout  16  SRAM data bus; driven only in write states, else hi-Z
- ram_en_n  output  1  SRAM chip enable, active-low; reset 1
- ram_oe_n  output  1  SRAM output enable, active-low; reset 1
- ram_we_n  output  1  SRAM write enable, active-low; reset 1

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: all strobes 1, bus hi-Z. memwrite_in=1 -> latch addr_in and wdata_in, go WR_SETUP. Else memread_in=1 -> latch addr_in, go RD. Both asserted: write wins, read ignored.
- RD: en_n=0, oe_n=0, we_n=1. On exit, sample ram_data into rdata_out, go DONE.
- WR_SETUP: en_n=0, oe_n=1, we_n=1, bus driven with latched data -> WR_PULSE.
- WR_PULSE: we_n=0, bus driven -> WR_HOLD.
- WR_HOLD: we_n=1, bus still driven -> DONE.
- DONE: strobes 1, bus hi-Z, stall_out=0, requests ignored -> IDLE.
- stall_out (combinational) = (IDLE and (memread_in or memwrite_in)) or state in {RD, WR_SETUP, WR_PULSE, WR_HOLD}.
- rdata_out changes only at the end of RD. It holds its value across writes and idle cycles.
- ram_addr holds its last latched value in IDLE/DONE.
- oe_n and we_n are never both 0; bus never driven while oe_n=0.

## Timing
- Cycle 0 is the first cycle a request is visible in IDLE; stall_out is 1 in that cycle.
- Read, without macro: RD in cycle 1, DONE in cycle 2. rdata_out is valid and stall_out=0 from cycle 2. Total 2 stall cycles.
- Write, without macro: WR_SETUP 1, WR_PULSE 2, WR_HOLD 3, DONE 4. Total 4 stall cycles.
- Back-to-back requests: a request held after DONE is re-evaluated in the following IDLE cycle. Minimum spacing is 3 cycles for reads and 5 for writes.
- Reset mid-operation: asynchronously forces IDLE, strobes 1, bus hi-Z, stall_out 0, rdata_out 0, ram_addr 0. A partially issued write is abandoned; SRAM contents are undefined for that address.
- Request inputs changing while not in IDLE are ignored; latched values are used.

## Configuration
- MEMPORT_WAIT_EN defined: RD and WR_PULSE each last 1+WAIT_CYCLES cycles, timed by a 4-bit down-counter loaded on state entry. Read stall = 2+WAIT_CYCLES cycles; write stall = 4+WAIT_CYCLES cycles. rdata_out is sampled on the last RD cycle.
- Undefined: RD and WR_PULSE last exactly one cycle; the counter and WAIT_CYCLES are unused.

## Test plan
- Reset asserted, then released with no requests -> all strobes 1, ram_data hi-Z, stall_out 0, rdata_out 0x0000.
- Store addr 0x0012, data 0xBEEF, no macro -> stall_out 1 for 4 cycles. WR_PULSE shows ram_addr 0x00012, we_n=0, bus 0xBEEF; DONE follows with stall_out 0.
- Load addr 0x0012 with SRAM model holding 0xBEEF -> oe_n=0 for 1 cycle, rdata_out=0xBEEF, stall_out low on cycle 2.
- memread_in and memwrite_in both 1 at addr 0x0040, data 0x1234 -> write performed and oe_n never asserted.
- With MEMPORT_WAIT_EN, WAIT_CYCLES=2: load -> oe_n low for 3 cycles, 4 stall cycles. Store -> we_n low for 3 cycles, 6 stall cycles.
- rst pulsed low during WR_PULSE -> we_n returns to 1 and bus goes hi-Z in the same cycle, stall_out 0, FSM in IDLE after release.
